// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared types and constants for elastic control pipeline stages
package ctrl_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic       reg_wr;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] wb_sel;
    logic       csr_rd;
    logic       csr_wr;
    logic       is_mret;
  } ctrl_fields_t;

  localparam int CTRL_FIELDS_W = $bits(ctrl_fields_t);

  // A bubble must never raise any write or CSR enable downstream.
  localparam ctrl_fields_t CTRL_BUBBLE_DEFAULT = '0;

  function automatic pipe_state_t state_of(input logic main_valid, input logic skid_valid);
    if (skid_valid) return FULL;
    if (main_valid) return ONE;
    return EMPTY;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - elastic valid/ready pipeline stage with 2-entry skid buffer and flush
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int                 CTRL_W      = 8,
  parameter int                 DATA_W      = 32,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  pipe_state_t       state;
  logic              accept;
  logic              drain;

  assign state = state_of(main_valid, skid_valid);

  // Registered skid_valid only: out_ready never reaches in_ready combinationally.
  assign in_ready = !rst && !skid_valid && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= CTRL_BUBBLE;
      skid_ctrl  <= CTRL_BUBBLE;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
          end else if (drain) begin
            main_valid <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(main_valid && !out_ready),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb/tb_ctrl_pipe_stage.sv - directed vector table plus queue-model random test for ctrl_pipe_stage
module tb_ctrl_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;

  wire         in_ready, out_valid;
  wire  [7:0]  out_ctrl;
  wire  [31:0] out_data;
  wire  [1:0]  occupancy;
  wire  [15:0] stall_cnt;

  wire         s_in_ready, s_out_valid;
  wire  [7:0]  s_out_ctrl;
  wire  [31:0] s_out_data;
  wire  [1:0]  s_occupancy;
  wire  [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ctrl_pipe_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic       iv;
    logic [7:0] ctrl;
    logic       ordy;
    logic       fl;
    logic       e_rdy;
    logic       e_valid;
    logic [7:0] e_ctrl;
    logic [1:0] e_occ;
    int         e_stall;
  } vec_t;

  vec_t vecs[$];

  function void add(input logic iv, input logic [7:0] ctrl, input logic ordy, input logic fl,
                    input logic e_rdy, input logic e_valid, input logic [7:0] e_ctrl,
                    input logic [1:0] e_occ, input int e_stall);
    vec_t v;
    v.iv = iv; v.ctrl = ctrl; v.ordy = ordy; v.fl = fl;
    v.e_rdy = e_rdy; v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.e_occ = e_occ; v.e_stall = e_stall;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  logic [39:0] q[$];
  int          m_stall;
  logic        e_rdy_r, rel, acc;

  initial begin
    // Streaming: each entry appears one cycle after acceptance, ready stays high.
    for (int k = 0; k < 8; k++)
      add(1'b1, 8'h10 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1, 8'h10 + 8'(k), 2'd1, 0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 0);
    // Backpressure: skid fills, ready drops, ordered drain.
    add(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 2'd1, 0);
    add(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 2'd2, 1);
    add(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 2'd2, 2);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 2'd2, 3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 2'd1, 3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 3);
    // Flush while FULL with in_valid high; reissued entry shows up once.
    add(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1, 3);
    add(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 2'd2, 4);
    add(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 5);
    add(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 2'd1, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 5);
    // Flush while ONE with release in the same cycle.
    add(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1, 5);
    add(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 5);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("init_out_valid", out_valid, 1'b0);
    check("init_in_ready", in_ready, 1'b1);

    // Mid-stream reset with both entries held.
    in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 32'hA1A1A1A1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_ctrl = 8'hA2; in_data = 32'hA2A2A2A2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("pre_rst_occupancy", occupancy, 2'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 8'h00);
    check("rst_out_data", out_data, 32'h0);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_ctrl   = vecs[i].ctrl;
      in_data   = {4{vecs[i].ctrl}};
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_out_ctrl", i), out_ctrl, vecs[i].e_ctrl);
      check($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
      check($sformatf("vec%0d_stall_cnt", i), stall_cnt, 64'(vecs[i].e_stall));
      check($sformatf("vec%0d_sat_stall", i), s_stall_cnt, 64'(sat15(vecs[i].e_stall)));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_out_data", i), out_data, {4{vecs[i].e_ctrl}});
    end
    in_valid = 1'b0; flush = 1'b0;

    // Saturation on the 4-bit instance, then flush must not clear it.
    in_valid = 1'b1; in_ctrl = 8'h99; in_data = 32'h99999999; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("sat_stall_15", s_stall_cnt, 4'd15);
    check("sat_wide_stall", stall_cnt, 16'd25);
    check("sat_out_ctrl", out_ctrl, 8'h99);
    flush = 1'b1;
    #1;
    check("sat_flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("sat_flush_occupancy", occupancy, 2'd0);
    check("sat_flush_out_valid", out_valid, 1'b0);
    check("sat_flush_out_ctrl", out_ctrl, 8'h00);
    check("sat_after_flush", s_stall_cnt, 4'd15);
    check("wide_after_flush", stall_cnt, 16'd26);

    m_stall = 26;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_ctrl   = 8'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      e_rdy_r = (q.size() < 2) && !flush;
      check("rnd_in_ready", in_ready, e_rdy_r);
      check("rnd_out_valid", out_valid, q.size() != 0);
      check("rnd_occupancy", occupancy, 64'(q.size()));
      if (q.size() != 0) begin
        check("rnd_out_ctrl", out_ctrl, q[0][39:32]);
        check("rnd_out_data", out_data, q[0][31:0]);
      end else begin
        check("rnd_bubble_ctrl", out_ctrl, 8'h00);
      end
      check("rnd_stall_cnt", stall_cnt, 64'(m_stall));
      check("rnd_sat_stall", s_stall_cnt, 64'(sat15(m_stall)));
      rel = (q.size() != 0) && out_ready;
      acc = in_valid && e_rdy_r;
      if ((q.size() != 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (rel) void'(q.pop_front());
        if (acc) q.push_back({in_ctrl, in_data});
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
# ctrl_pipe_stage

Parametrised elastic pipeline stage for control and payload fields between core pipeline stages (for example, the memory-to-writeback boundary). It replaces the fixed-field enable/hold stage register with a valid/ready handshake, a two-entry skid buffer for full throughput under backpressure, and a synchronous flush. Control bits are forced to a safe bubble value whenever the stage is empty, so downstream write enables never fire on a bubble. A saturating counter records backpressure cycles for performance debug.

## Interface
- CTRL_W, 8: width of the control vector (reg_wr, wr_en, rd_en, wb_sel[1:0], csr_rd, csr_wr, is_mret).
- DATA_W, 32: width of the payload vector.
- CTRL_BUBBLE, '0: value driven on out_ctrl when out_valid=0 and after reset.
- CNT_W, 16: width of the stall counter.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_W  upstream control.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  control, masked to CTRL_BUBBLE when out_valid=0.
- out_data  output  DATA_W  payload; value is don't-care when out_valid=0.
- occupancy  output  2  number of held entries (0..2).
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: main register (drives outputs) and skid register, each with its own valid bit.
- States, encoded from the valid bits: EMPTY (none held), ONE (main only), FULL (main and skid).
- Accept: in_valid and in_ready. Release: out_valid and out_ready.
- in_ready = !skid_valid and !flush.
- EMPTY: accept moves to ONE and loads main.
- ONE: accept with release reloads main and stays in ONE. Accept without release loads skid and moves to FULL. Release without accept moves to EMPTY.
- FULL: release moves the skid entry into main and goes to ONE. There is no accept, because in_ready=0.
- Flush takes priority over everything else. Next state is EMPTY, both valid bits clear, and no accept happens in the flush cycle. Any release already presented that cycle still counts as a completed transfer downstream.
- Reset has priority over flush.
- out_ctrl = main_valid ? main_ctrl : CTRL_BUBBLE.
- stall_cnt increments by 1 on each stall cycle and saturates at 2^CNT_W-1. Only rst clears it; flush does not.
- occupancy = main_valid + skid_valid.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- Throughput is 1 entry per cycle while out_ready=1.
- in_ready depends only on registered skid_valid and on flush. There is no combinational path from out_ready to in_ready.
- Reset values (checked the cycle after rst is sampled high):
  - out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0
  - occupancy=0, stall_cnt=0
  - internal valid bits 0
  - in_ready=0 while rst is high, 1 on the first cycle after reset.
- Reset applied mid-operation discards all entries in the same edge.
- Flush with in_valid=1: the input is not accepted and upstream must hold or reissue it.

## Structure
- Shared package ctrl_pipe_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - a packed struct for the CTRL_W=8 control fields, so stages can cast to and from the vector;
  - the CTRL_BUBBLE default constant.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt) implements stall_cnt.
- Everything else stays in one always_ff block plus a combinational output mask.

## Test plan
- Reset: hold rst for 2 cycles mid-stream with occupancy=2. Next cycle: out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming: send 8 back-to-back entries with out_ready=1. Each emerges 1 cycle later, in order, with in_ready constantly 1.
- Backpressure: send ctrl=0x81 then 0x42 with out_ready=0.
  - occupancy reaches 2 and in_ready drops to 0.
  - stall_cnt advances 1 per cycle.
  - Raising out_ready delivers 0x81 then 0x42 on consecutive cycles.
- Flush: with FULL and in_valid=1, pulse flush for 1 cycle.
  - Next cycle: occupancy=0, out_valid=0, out_ctrl=CTRL_BUBBLE.
  - The flush-cycle input does not appear at the output.
- Saturation: with CNT_W=4, stall for 20 cycles. stall_cnt stops at 15, and a flush does not clear it.
- Random: random in_valid/out_ready/flush over 10k cycles, checked against a queue model. Check ordering, no duplicates, and that out_ctrl equals CTRL_BUBBLE whenever out_valid=0.
